alu_share_arbiter: RTL

//  Shares one combinational 4-bit ALU (8 ops: 0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 signed A>B, 7 A==B)

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter that time-shares one external 4-bit ALU over valid/ready channels.
// Optional per-port completed-op counters are enabled by defining ALU_STATS_EN.
module alu_share_arbiter #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] i_req_valid,
    output logic [NPORT-1:0] o_req_ready,
    input  logic [5:0]       i_req_op,
    input  logic [7:0]       i_req_a,
    input  logic [7:0]       i_req_b,
    output logic [NPORT-1:0] o_rsp_valid,
    input  logic [NPORT-1:0] i_rsp_ready,
    output logic [3:0]       o_rsp_result,
    output logic [2:0]       o_rsp_flags,
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [2:0]       o_alu_sel,
    input  logic [3:0]       i_alu_result,
    input  logic             i_alu_out,
    input  logic             i_alu_over,
    input  logic             i_alu_c
`ifdef ALU_STATS_EN
    ,
    output logic [CNT_W-1:0] o_stat_cnt0,
    output logic [CNT_W-1:0] o_stat_cnt1
`endif
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned DAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    generate
        if (NPORT != 2) begin : g_bad_nport
            $error("alu_share_arbiter supports NPORT == 2 only");
        end
        if (CNT_W == 0) begin : g_bad_cnt_w
            $error("alu_share_arbiter requires CNT_W >= 1");
        end
    endgenerate

    state_t r_state;
    logic   r_last_grant;
    logic   r_owner;

    logic             w_grant;
    logic             w_accept;
    logic [OP_W-1:0]  w_op;
    logic [DAT_W-1:0] w_a;
    logic [DAT_W-1:0] w_b;

    // Round-robin pick: on conflict the port that did not win last time is served.
    always_comb begin
        w_grant = 1'b0;
        if (i_req_valid[0] && i_req_valid[1]) begin
            w_grant = ~r_last_grant;
        end else if (i_req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign w_accept    = !rst && (r_state == IDLE) && (|i_req_valid);
    assign o_req_ready = w_accept ? (w_grant ? NPORT'(2'b10) : NPORT'(2'b01)) : '0;

    assign w_op = w_grant ? i_req_op[5:3] : i_req_op[2:0];
    assign w_a  = w_grant ? i_req_a[7:4]  : i_req_a[3:0];
    assign w_b  = w_grant ? i_req_b[7:4]  : i_req_b[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            o_rsp_valid  <= '0;
            o_rsp_result <= '0;
            o_rsp_flags  <= '0;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_alu_sel    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        o_alu_a   <= w_a;
                        o_alu_b   <= w_b;
                        o_alu_sel <= w_op;
                        r_owner   <= w_grant;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_flags  <= {i_alu_out, i_alu_over, i_alu_c};
                    o_rsp_valid  <= r_owner ? NPORT'(2'b10) : NPORT'(2'b01);
                    r_state      <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready[r_owner]) begin
                        o_rsp_valid  <= '0;
                        r_last_grant <= r_owner;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_STATS_EN
    // Saturating completion counters, bumped on the response handshake of the owning port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stat_cnt0 <= '0;
            o_stat_cnt1 <= '0;
        end else if (r_state == RESP && i_rsp_ready[r_owner]) begin
            if (!r_owner && o_stat_cnt0 != {CNT_W{1'b1}}) begin
                o_stat_cnt0 <= o_stat_cnt0 + CNT_W'(1);
            end
            if (r_owner && o_stat_cnt1 != {CNT_W{1'b1}}) begin
                o_stat_cnt1 <= o_stat_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule
